migcorre_btn_conditioner: RTL and testbench

- Upstream stage of the duty-cycle PWM. Conditions the two raw push-button inputs (increase, decrease) before they reach the PWM's duty-adjust inputs.
- Per channel: 2-flop synchroniser, counter-based debounce, and a single-cycle press pulse.
- Outputs drive the PWM's increase_duty_in / decrease_duty_in directly. Each press yields exactly one duty step.

---
 rtl/migcorre_btn_pkg.sv | 12 +
 rtl/migcorre_btn_debounce.sv | 98 +++++++++
 rtl/migcorre_btn_conditioner.sv | 67 ++++++
 tb/tb_migcorre_btn_conditioner.sv | 121 ++++++++++++
 4 files changed

// File: rtl/migcorre_btn_pkg.sv
// Shared defaults and types for the push-button conditioner.
// Optional auto-repeat is enabled with BTN_AUTOREPEAT_EN.
package migcorre_btn_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int REPEAT_DELAY_DEF    = 200;
   localparam int REPEAT_PERIOD_DEF   = 50;
   localparam int CNT_W_DEF           = 8;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/migcorre_btn_debounce.sv
// One button channel: 2-flop sync, counter debounce, rise pulse.
// Auto-repeat pulses are added when BTN_AUTOREPEAT_EN is defined.
module migcorre_btn_debounce
   import migcorre_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_lvl,
   output logic o_pulse
);

   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       (2 ** CNT_W) <= DEBOUNCE_CYCLES || (2 ** CNT_W) <= REPEAT_DELAY ||
       (2 ** CNT_W) <= REPEAT_PERIOD) begin : g_bad_cfg
      $error("migcorre_btn_debounce: illegal parameter set");
   end

   logic             r_sync1;
   logic             r_sync2;
   logic             r_lvl;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;

   logic w_flip;
   logic w_lvl_nxt;
   logic w_rise;

   assign w_flip    = (r_sync2 != r_lvl) && (r_cnt == DB_MAX);
   assign w_lvl_nxt = w_flip ? r_sync2 : r_lvl;
   assign w_rise    = w_flip & r_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_lvl   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_lvl) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_lvl <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(REPEAT_PERIOD - 1);

   logic             r_rphase;
   logic [CNT_W-1:0] r_rcnt;
   logic             w_rep;

   // Timing restarts on the press edge; phase 0 waits DELAY, then PERIOD.
   assign w_rep = r_lvl && w_lvl_nxt &&
                  (r_rcnt == (r_rphase ? PER_MAX : DLY_MAX));

   always_ff @(posedge clk) begin
      if (reset || !r_lvl || !w_lvl_nxt) begin
         r_rcnt   <= '0;
         r_rphase <= 1'b0;
      end else if (w_rep) begin
         r_rcnt   <= '0;
         r_rphase <= 1'b1;
      end else begin
         r_rcnt <= r_rcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_pulse <= 1'b0;
      else       r_pulse <= w_rise | w_rep;
   end
`else
   always_ff @(posedge clk) begin
      if (reset) r_pulse <= 1'b0;
      else       r_pulse <= w_rise;
   end
`endif

   assign o_lvl   = r_lvl;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/migcorre_btn_conditioner.sv
// Two-button conditioner feeding the PWM duty-adjust inputs.
// Optional auto-repeat is enabled with BTN_AUTOREPEAT_EN.
module migcorre_btn_conditioner
   import migcorre_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic increase_btn_in,
   input  logic decrease_btn_in,
   output logic increase_pulse_out,
   output logic decrease_pulse_out,
   output logic increase_level_out,
   output logic decrease_level_out
);

   logic w_inc_lvl;
   logic w_inc_pulse;
   logic w_dec_lvl;
   logic w_dec_pulse;

   migcorre_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_inc (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (increase_btn_in),
      .o_lvl   (w_inc_lvl),
      .o_pulse (w_inc_pulse)
   );

   migcorre_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_dec (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (decrease_btn_in),
      .o_lvl   (w_dec_lvl),
      .o_pulse (w_dec_pulse)
   );

   // Raw pulse and levels share the same edge, so a pulse is dropped
   // whenever the opposite level is high after that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         increase_pulse_out <= 1'b0;
         decrease_pulse_out <= 1'b0;
      end else begin
         increase_pulse_out <= w_inc_pulse & ~w_dec_lvl;
         decrease_pulse_out <= w_dec_pulse & ~w_inc_lvl;
      end
   end

   assign increase_level_out = w_inc_lvl;
   assign decrease_level_out = w_dec_lvl;

endmodule

// File: tb/tb_migcorre_btn_conditioner.sv
// Directed bench for migcorre_btn_conditioner (DEBOUNCE=4, DELAY=8, PERIOD=4).
// Expectations follow BTN_AUTOREPEAT_EN when it is defined.
module tb_migcorre_btn_conditioner;

   logic clk = 1'b0;
   logic reset;
   logic inc_btn;
   logic dec_btn;
   logic inc_pulse;
   logic dec_pulse;
   logic inc_lvl;
   logic dec_lvl;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   migcorre_btn_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (8),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (4)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .increase_btn_in    (inc_btn),
      .decrease_btn_in    (dec_btn),
      .increase_pulse_out (inc_pulse),
      .decrease_pulse_out (dec_pulse),
      .increase_level_out (inc_lvl),
      .decrease_level_out (dec_lvl)
   );

   task automatic check(input string tag, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", tag, act, exp);
      end
   endtask

   // Inputs set here are sampled at the next rising edge.
   task automatic tick(input logic r, input logic i, input logic d);
      reset   = r;
      inc_btn = i;
      dec_btn = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string sc, input int k,
                       input logic ip, input logic il,
                       input logic dp, input logic dl);
      check($sformatf("%s.k%0d.inc_pulse", sc, k), inc_pulse, ip);
      check($sformatf("%s.k%0d.inc_lvl", sc, k), inc_lvl, il);
      check($sformatf("%s.k%0d.dec_pulse", sc, k), dec_pulse, dp);
      check($sformatf("%s.k%0d.dec_lvl", sc, k), dec_lvl, dl);
   endtask

   // Press held for h samples from k=0; [s0,s1] are suppressed pulses.
   // Level falls at edge h+5, so a repeat after edge h+5 cannot occur.
   function automatic logic exp_p(input int k, input int h,
                                  input int s0, input int s1);
      if (k >= s0 && k <= s1) return 1'b0;
      if (k == 6) return 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      if (k >= 14 && (k - 14) % 4 == 0 && k <= h + 5) return 1'b1;
`endif
      return 1'b0;
   endfunction

   initial begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk4("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 28; k++) begin
         tick(1'b0, k < 20, 1'b0);
         chk4("press", k, exp_p(k, 20, -1, -1),
              k >= 5 && k <= 24, 1'b0, 1'b0);
      end

      for (int k = 0; k < 20; k++) begin
         tick(1'b0, k < 10 && k % 2 == 0, 1'b0);
         chk4("bounce", k, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 13; k++) begin
         tick(1'b0, k < 3, 1'b0);
         chk4("short", k, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      for (int k = 0; k < 29; k++) begin
         tick(1'b0, k < 20, k < 10);
         chk4("simul", k, exp_p(k, 20, 0, 14), k >= 5 && k <= 24,
              1'b0, k >= 5 && k <= 14);
      end

      for (int k = 0; k < 61; k++) begin
         tick(1'b0, k < 30, (k >= 10 && k < 16) || (k >= 40 && k < 50));
         chk4("overlap", k, exp_p(k, 30, 18, 18), k >= 5 && k <= 34,
              (k >= 40) ? exp_p(k - 40, 10, -1, -1) : 1'b0,
              (k >= 15 && k <= 20) || (k >= 45 && k <= 54));
      end

      for (int k = 0; k < 35; k++) begin
         tick(k == 3, k < 26, 1'b0);
         if (k < 4)
            chk4("rst", k, 1'b0, 1'b0, 1'b0, 1'b0);
         else
            chk4("rst", k, exp_p(k - 4, 22, -1, -1),
                 k >= 9 && k <= 30, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
